csr_timer_bank: RTL

Parametrised multi-channel countdown timer bank that extends the single TCFG/TVAL/TICLR timer held in the CSR file. It provides NUM_TIMERS independent one-shot/periodic timers, a shared programmable prescaler, a free-running 64-bit stable counter and per-channel interrupt pending bits. The bank sits next to the CSR file on the CSR read/write bus. Its interrupt lines feed the ESTAT interrupt-status inputs.

---
 rtl/csr_timer_bank_if.sv | 26 ++
 rtl/csr_timer_bank.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/csr_timer_bank_if.sv
// CSR read/write bus shared by the CSR file and the timer bank.
// The master drives address, data and write strobe; the slave returns
// combinational read data for the presented read address.
interface csr_timer_bank_if;
    logic        csr_wen;
    logic [13:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic [13:0] csr_raddr;
    logic [31:0] csr_rdata;

    modport master (
        output csr_wen,
        output csr_waddr,
        output csr_wdata,
        output csr_raddr,
        input  csr_rdata
    );

    modport slave (
        input  csr_wen,
        input  csr_waddr,
        input  csr_wdata,
        input  csr_raddr,
        output csr_rdata
    );
endinterface

// File: rtl/csr_timer_bank.sv
// Multi-channel countdown timer bank living next to the CSR file.
// Each channel has TCFG/TVAL/TICLR registers at BASE_ADDR+4i; all channels
// share one prescaler. A free-running 64-bit stable counter is also kept here.
module csr_timer_bank #(
    parameter int          NUM_TIMERS  = 4,
    parameter int          CNT_WIDTH   = 32,
    parameter int          PRESC_WIDTH = 8,
    parameter logic [13:0] BASE_ADDR   = 14'h200
) (
    input  logic                  clk,
    input  logic                  reset,
    csr_timer_bank_if.slave       csr,
    output logic [NUM_TIMERS-1:0] timer_irq,
    output logic                  irq_any,
    output logic [63:0]           timer_64
);

    localparam int IW = CNT_WIDTH - 2;
    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    logic [PRESC_WIDTH-1:0] presc_q;
    logic [PRESC_WIDTH-1:0] pcnt_q;
    logic                   tick;

    logic [NUM_TIMERS-1:0]  en_q;
    logic [NUM_TIMERS-1:0]  per_q;
    logic [NUM_TIMERS-1:0]  pend_q;
    logic [IW-1:0]          init_q [NUM_TIMERS];
    logic [CNT_WIDTH-1:0]   tval_q [NUM_TIMERS];

    logic [13:0]            woff;
    logic                   wr_map;
    logic                   presc_we;
    logic [NUM_TIMERS-1:0]  tcfg_we;
    logic [NUM_TIMERS-1:0]  ticlr_we;
    logic [NUM_TIMERS-1:0]  pend_set;

    logic [13:0]            roff;
    logic                   rd_map;
    logic [2:0]             rch;
    logic [1:0]             rreg;

    // Write decode: offsets are only meaningful at or above the base address,
    // so the subtraction never wraps for a mapped access.
    assign woff     = csr.csr_waddr - BASE_ADDR;
    assign wr_map   = csr.csr_wen && (csr.csr_waddr >= BASE_ADDR);
    assign presc_we = wr_map && (woff == 14'd32);

    // Per-channel write strobes; channels beyond NUM_TIMERS never match.
    always_comb begin
        for (int i = 0; i < NUM_TIMERS; i++) begin
            tcfg_we[i]  = wr_map && (woff == 14'(4 * i));
            ticlr_we[i] = wr_map && (woff == 14'(4 * i + 2)) && csr.csr_wdata[0];
        end
    end

    assign tick = (pcnt_q == presc_q);

    // Shared prescaler: counts 0..PRESC, restarting whenever PRESC is rewritten.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            pcnt_q  <= '0;
        end else if (presc_we) begin
            presc_q <= csr.csr_wdata[PRESC_WIDTH-1:0];
            pcnt_q  <= '0;
        end else if (tick) begin
            pcnt_q  <= '0;
        end else begin
            pcnt_q  <= pcnt_q + 1'b1;
        end
    end

    // Pending is raised on the 1->0 tick, or on every reload tick when a
    // periodic channel reloads to zero. A same-cycle TCFG write suppresses it.
    always_comb begin
        for (int i = 0; i < NUM_TIMERS; i++) begin
            pend_set[i] = !tcfg_we[i] && tick && en_q[i] &&
                          ((tval_q[i] == ONE) ||
                           ((tval_q[i] == '0) && per_q[i] && (init_q[i] == '0)));
        end
    end

    // Channel configuration, countdown and pending bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            en_q   <= '0;
            per_q  <= '0;
            pend_q <= '0;
            for (int i = 0; i < NUM_TIMERS; i++) begin
                init_q[i] <= '0;
                tval_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_TIMERS; i++) begin
                if (tcfg_we[i]) begin
                    en_q[i]   <= csr.csr_wdata[0];
                    per_q[i]  <= csr.csr_wdata[1];
                    init_q[i] <= csr.csr_wdata[CNT_WIDTH-1:2];
                    tval_q[i] <= {csr.csr_wdata[CNT_WIDTH-1:2], 2'b00};
                end else if (tick && en_q[i]) begin
                    if (tval_q[i] > ONE) begin
                        tval_q[i] <= tval_q[i] - ONE;
                    end else if (tval_q[i] == ONE) begin
                        tval_q[i] <= '0;
                    end else if (per_q[i]) begin
                        tval_q[i] <= {init_q[i], 2'b00};
                    end
                end
                pend_q[i] <= pend_set[i] | (pend_q[i] & ~ticlr_we[i]);
            end
        end
    end

    // Stable counter runs every cycle regardless of the prescaler.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_64 <= '0;
        end else begin
            timer_64 <= timer_64 + 64'd1;
        end
    end

    assign roff   = csr.csr_raddr - BASE_ADDR;
    assign rd_map = (csr.csr_raddr >= BASE_ADDR);
    assign rch    = roff[4:2];
    assign rreg   = roff[1:0];

    // Combinational read mux; TICLR, reserved and absent channels read 0.
    always_comb begin
        csr.csr_rdata = '0;
        if (rd_map && (roff < 14'd32)) begin
            for (int i = 0; i < NUM_TIMERS; i++) begin
                if (rch == 3'(i)) begin
                    case (rreg)
                        2'd0:    csr.csr_rdata = 32'({init_q[i], per_q[i], en_q[i]});
                        2'd1:    csr.csr_rdata = 32'(tval_q[i]);
                        default: csr.csr_rdata = '0;
                    endcase
                end
            end
        end else if (rd_map && (roff == 14'd32)) begin
            csr.csr_rdata = 32'(presc_q);
        end else if (rd_map && (roff == 14'd33)) begin
            csr.csr_rdata = 32'(pend_q);
        end
    end

    assign timer_irq = pend_q;
    assign irq_any   = |pend_q;

endmodule
